// File: rtl/rf_pkg.sv
// Shared widths, the r0 address and the arbiter state encoding for the RF writeback arbiter.
// Latency: none (definitions only).
// Backpressure: not applicable.
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Register r0 is hard-wired to zero, so writes to it are swallowed.
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Arbiter states: normal fixed priority to port 0, or a forced port-1 grant.
    localparam logic [0:0] ARB_P0 = 1'b0;
    localparam logic [0:0] ARB_P1 = 1'b1;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Two writeback request channels (pipeline and MDU) into the RF write-port arbiter.
// Latency: none (wires only).
// Backpressure: valid/ready per channel; the ready can depend on valid, valid never depends on ready.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic              p0_valid;
    logic              p0_ready;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_data;
    logic              p1_valid;
    logic              p1_ready;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_data;
    logic              p1_dropped;

    modport master (
        output p0_valid, p0_addr, p0_data,
        output p1_valid, p1_addr, p1_data,
        input  p0_ready, p1_ready, p1_dropped
    );

    modport slave (
        input  p0_valid, p0_addr, p0_data,
        input  p1_valid, p1_addr, p1_data,
        output p0_ready, p1_ready, p1_dropped
    );
endinterface

// File: rtl/rf_wr_stage.sv
// Registered RF write stage: turns a one-cycle grant into RFWr/A3/WD and a WAW-drop pulse.
// Latency: 1 cycle from grant to RFWr; the RF captures on the following edge.
// Backpressure: none; it accepts a grant every cycle.
module rf_wr_stage
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant_vld,
    input  logic [ADDR_W-1:0] grant_addr,
    input  logic [DATA_W-1:0] grant_data,
    input  logic              kill,
    output logic              RFWr,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD,
    output logic              p1_dropped
);
    logic              rf_wr_d, rf_wr_q;
    logic [ADDR_W-1:0] a3_d, a3_q;
    logic [DATA_W-1:0] wd_d, wd_q;
    logic              drop_d, drop_q;

    // Next-state: a grant loads address/data; r0 targets still load but never raise RFWr.
    always_comb begin
        rf_wr_d = grant_vld && (grant_addr != ADDR_W'(ZERO_REG));
        a3_d    = a3_q;
        wd_d    = wd_q;
        drop_d  = kill;
        if (grant_vld) begin
            a3_d = grant_addr;
            wd_d = grant_data;
        end
    end

    // Output registers, cleared immediately by reset so a pending write is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_q <= 1'b0;
            a3_q    <= '0;
            wd_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            rf_wr_q <= rf_wr_d;
            a3_q    <= a3_d;
            wd_q    <= wd_d;
            drop_q  <= drop_d;
        end
    end

    assign RFWr       = rf_wr_q;
    assign A3         = a3_q;
    assign WD         = wd_q;
    assign p1_dropped = drop_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RF write port between pipeline writeback (p0) and the MDU (p1).
// Latency: handshake at edge N drives RFWr during cycle N+1 (registered output).
// Backpressure: p0 priority; p1 forced through after MAX_WAIT losses; same-address p1 losses are dropped.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int MAX_WAIT = 4,
    parameter int KILL_WAW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wb_arbiter_if.slave    wb,
    output logic              RFWr,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [0:0]        state_d, state_q;
    logic [3:0]        wait_cnt_d, wait_cnt_q;
    logic              waw;
    logic              p0_rdy_raw, p1_rdy_raw;
    logic              p0_hs, p1_hs, kill;
    logic              grant_vld;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              p1_drop;

    // Ready generation: p0 wins in the normal state unless the two collide on one address,
    // in which case both are accepted and the older p1 result is discarded.
    always_comb begin
        waw = (KILL_WAW != 0) && wb.p0_valid && wb.p1_valid && (wb.p0_addr == wb.p1_addr);
        if (state_q == ARB_P0) begin
            p0_rdy_raw = 1'b1;
            p1_rdy_raw = wb.p1_valid && (!wb.p0_valid || waw);
        end else begin
            p1_rdy_raw = 1'b1;
            p0_rdy_raw = !wb.p1_valid;
        end
    end

    assign wb.p0_ready = rst_n && p0_rdy_raw;
    assign wb.p1_ready = rst_n && p1_rdy_raw;
    assign p0_hs       = wb.p0_valid && wb.p0_ready;
    assign p1_hs       = wb.p1_valid && wb.p1_ready;
    assign kill        = waw && (state_q == ARB_P0) && p1_hs;

    // Grant selection: at most one source reaches the write stage per cycle.
    always_comb begin
        grant_vld  = 1'b0;
        grant_addr = wb.p0_addr;
        grant_data = wb.p0_data;
        if (p1_hs && !kill) begin
            grant_vld  = 1'b1;
            grant_addr = wb.p1_addr;
            grant_data = wb.p1_data;
        end else if (p0_hs) begin
            grant_vld = 1'b1;
        end
    end

    // Starvation counter and state: count p1 losses, force a p1 grant when the count hits MAX_WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (wb.p1_valid && !wb.p1_ready) begin
            if (wait_cnt_q != MAX_CNT) begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
            if ((state_q == ARB_P0) && (wait_cnt_d == MAX_CNT)) begin
                state_d = ARB_P1;
            end
        end else begin
            wait_cnt_d = 4'd0;
            state_d    = ARB_P0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_P0;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    rf_wr_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wr_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .grant_vld  (grant_vld),
        .grant_addr (grant_addr),
        .grant_data (grant_data),
        .kill       (kill),
        .RFWr       (RFWr),
        .A3         (A3),
        .WD         (WD),
        .p1_dropped (p1_drop)
    );

    assign wb.p1_dropped = p1_drop;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: vectors push the expected RF write, a monitor pops and compares.
// Latency: expectations are consumed one cycle after the handshake edge.
// Backpressure: readies are checked against hand-computed values in every vector.
module tb_rf_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;

    rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) wbif ();

    rf_wb_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .MAX_WAIT (4),
        .KILL_WAW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wbif.slave),
        .RFWr  (RFWr),
        .A3    (A3),
        .WD    (WD)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
        logic        drop;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: one expectation per cycle; with none queued the RF port must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("mon_rfwr", 64'(RFWr), 64'(mon_e.wr));
                if (mon_e.wr) begin
                    chk("mon_a3", 64'(A3), 64'(mon_e.a));
                    chk("mon_wd", 64'(WD), 64'(mon_e.d));
                end
                chk("mon_dropped", 64'(wbif.p1_dropped), 64'(mon_e.drop));
            end else begin
                chk("idle_rfwr", 64'(RFWr), 64'd0);
                chk("idle_dropped", 64'(wbif.p1_dropped), 64'd0);
            end
        end
    end

    task automatic drive(input logic p0v, input logic [4:0] p0a, input logic [31:0] p0d,
                         input logic p1v, input logic [4:0] p1a, input logic [31:0] p1d);
        wbif.p0_valid = p0v;
        wbif.p0_addr  = p0a;
        wbif.p0_data  = p0d;
        wbif.p1_valid = p1v;
        wbif.p1_addr  = p1a;
        wbif.p1_data  = p1d;
    endtask

    // One cycle: drive, check readies, queue the RF write expected on the next cycle.
    task automatic v(input string nm,
                     input logic p0v, input logic [4:0] p0a, input logic [31:0] p0d,
                     input logic p1v, input logic [4:0] p1a, input logic [31:0] p1d,
                     input logic e0r, input logic e1r,
                     input logic ewr, input logic [4:0] ea, input logic [31:0] ed, input logic edr);
        @(negedge clk);
        drive(p0v, p0a, p0d, p1v, p1a, p1d);
        #1;
        chk({nm, "_p0_ready"}, 64'(wbif.p0_ready), 64'(e0r));
        chk({nm, "_p1_ready"}, 64'(wbif.p1_ready), 64'(e1r));
        sbq.push_back('{ewr, ea, ed, edr});
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd9, 32'hDEAD_BEEF);
        #2;
        chk("rst_p0_ready", 64'(wbif.p0_ready), 64'd0);
        chk("rst_p1_ready", 64'(wbif.p1_ready), 64'd0);
        chk("rst_rfwr", 64'(RFWr), 64'd0);
        chk("rst_a3", 64'(A3), 64'd0);
        chk("rst_wd", 64'(WD), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_p0_ready", 64'(wbif.p0_ready), 64'd1);
        chk("rel_p1_ready", 64'(wbif.p1_ready), 64'd0);
        @(posedge clk);

        // Port 0 alone, then an r0 write, then idle.
        v("p0_a5", 1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'd0, 1, 0, 1, 5'd5, 32'h1234_5678, 0);
        v("p0_r0", 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 1, 0, 0, 5'd0, 32'd0, 0);
        v("idle",  0, 5'd0, 32'd0,         0, 5'd0, 32'd0, 1, 0, 0, 5'd0, 32'd0, 0);

        // Starvation: four p1 losses, then a forced p1 grant, then p0 resumes.
        v("starve1", 1, 5'd3, 32'h31, 1, 5'd9, 32'hDEAD_BEEF, 1, 0, 1, 5'd3, 32'h31, 0);
        v("starve2", 1, 5'd3, 32'h32, 1, 5'd9, 32'hDEAD_BEEF, 1, 0, 1, 5'd3, 32'h32, 0);
        v("starve3", 1, 5'd3, 32'h33, 1, 5'd9, 32'hDEAD_BEEF, 1, 0, 1, 5'd3, 32'h33, 0);
        v("starve4", 1, 5'd3, 32'h34, 1, 5'd9, 32'hDEAD_BEEF, 1, 0, 1, 5'd3, 32'h34, 0);
        v("forced",  1, 5'd3, 32'h35, 1, 5'd9, 32'hDEAD_BEEF, 0, 1, 1, 5'd9, 32'hDEAD_BEEF, 0);
        v("resume",  1, 5'd3, 32'h35, 0, 5'd0, 32'd0,         1, 0, 1, 5'd3, 32'h35, 0);

        // WAW kill in the normal state: both accepted, only p0 data reaches the RF.
        v("waw_kill", 1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 1, 1, 1, 5'd7, 32'd1, 1);

        // Reach the forced state, then collide on r7: p1 first, p0 next, no drop.
        v("fc_lose1", 1, 5'd4, 32'h41, 1, 5'd7, 32'd2, 1, 0, 1, 5'd4, 32'h41, 0);
        v("fc_lose2", 1, 5'd4, 32'h42, 1, 5'd7, 32'd2, 1, 0, 1, 5'd4, 32'h42, 0);
        v("fc_lose3", 1, 5'd4, 32'h43, 1, 5'd7, 32'd2, 1, 0, 1, 5'd4, 32'h43, 0);
        v("fc_lose4", 1, 5'd4, 32'h44, 1, 5'd7, 32'd2, 1, 0, 1, 5'd4, 32'h44, 0);
        v("fc_p1",    1, 5'd7, 32'd1,  1, 5'd7, 32'd2, 0, 1, 1, 5'd7, 32'd2,  0);
        v("fc_p0",    1, 5'd7, 32'd1,  0, 5'd0, 32'd0, 1, 0, 1, 5'd7, 32'd1,  0);

        // Withdrawing the p1 request clears the loss count.
        v("wd_lose1", 1, 5'd4, 32'h51, 1, 5'd8, 32'h88, 1, 0, 1, 5'd4, 32'h51, 0);
        v("wd_lose2", 1, 5'd4, 32'h52, 1, 5'd8, 32'h88, 1, 0, 1, 5'd4, 32'h52, 0);
        v("wd_off",   1, 5'd4, 32'h53, 0, 5'd8, 32'h88, 1, 0, 1, 5'd4, 32'h53, 0);
        v("wd_lose3", 1, 5'd4, 32'h54, 1, 5'd8, 32'h88, 1, 0, 1, 5'd4, 32'h54, 0);
        v("wd_lose4", 1, 5'd4, 32'h55, 1, 5'd8, 32'h88, 1, 0, 1, 5'd4, 32'h55, 0);
        v("wd_lose5", 1, 5'd4, 32'h56, 1, 5'd8, 32'h88, 1, 0, 1, 5'd4, 32'h56, 0);
        v("wd_lose6", 1, 5'd4, 32'h57, 1, 5'd8, 32'h88, 1, 0, 1, 5'd4, 32'h57, 0);

        // Async reset in the forced state while RFWr is high, between clock edges.
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h55, 1'b1, 5'd8, 32'h88);
        #1;
        chk("mid_p0_ready", 64'(wbif.p0_ready), 64'd0);
        chk("mid_p1_ready", 64'(wbif.p1_ready), 64'd1);
        chk("mid_pre_rfwr", 64'(RFWr), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rfwr", 64'(RFWr), 64'd0);
        chk("arst_a3", 64'(A3), 64'd0);
        chk("arst_wd", 64'(WD), 64'd0);
        chk("arst_p0_ready", 64'(wbif.p0_ready), 64'd0);
        chk("arst_p1_ready", 64'(wbif.p1_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_p0_ready", 64'(wbif.p0_ready), 64'd1);
        chk("post_rst_p1_ready", 64'(wbif.p1_ready), 64'd0);
        sbq.push_back('{1'b1, 5'd4, 32'h55, 1'b0});
        @(posedge clk);

        v("tail1", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 0, 0, 5'd0, 32'd0, 0);
        v("tail2", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 0, 0, 5'd0, 32'd0, 0);

        @(negedge clk);
        #2;
        mon_en = 1'b0;
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
